uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N2 receiver. It uses a 16x oversampling fractional baud generator with a 3-sample majority vote. Character format is configurable: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits. It detects framing, parity, break and overrun conditions, and buffers good characters in a show-ahead FIFO with a valid/ready read port that feeds the core's MMIO UART register block.

Parameters:
SYSCLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in baud; 16*BAUD_RATE <= SYSCLK_FREQ
DATA_BITS, 8, data bits per character, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
uart_rx  in  1  asynchronous serial line, idle high
rd_data  out  DATA_BITS  FIFO head character, LSB = first bit received
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts rd_data this cycle
frame_err  out  1  one-cycle pulse: stop bit(s) sampled low (non-break)
parity_err  out  1  one-cycle pulse: parity mismatch
break_det  out  1  one-cycle pulse: break detected
overrun  out  1  one-cycle pulse: good character dropped because FIFO full
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1): state IDLE; synchroniser flops = 1; accumulator, sample counter and bit counter = 0; FIFO empty; rd_data = 0; rd_valid = 0; all pulses = 0; fifo_count = 0. Reset mid-frame discards the partial character.
- Input path: 2-flop synchroniser plus 1 history flop. Falling edge = history 1, synchronised 0.
- Baud tick: 32-bit accumulator. Each clk: acc += 16*BAUD_RATE; if the result >= SYSCLK_FREQ, subtract SYSCLK_FREQ and assert tick for that cycle. acc is cleared and the 4-bit sample counter is zeroed on start detection. Accumulator runs only outside IDLE and BREAK_WAIT.
- Sampling: the sample counter increments per tick and wraps 15->0. Flops capture the line on counts 7, 8 and 9. The bit value is the majority of the three, decided at count 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START on falling edge.
- START: if the start-bit majority is 1 -> IDLE (glitch reject, no flags). Otherwise -> DATA at count 15.
- DATA: shifts DATA_BITS bits LSB first. After the last bit -> PARITY if PARITY != 0, else -> STOP.
- PARITY: odd mode requires XOR(data, p) = 1; even mode requires it = 0. Result is held until frame end.
- STOP: checks STOP_BITS stop bits. The frame decision is made at count 9 of the last stop bit. The FSM then leaves STOP immediately (does not wait for the bit end), so back-to-back frames are received.
- Frame decision priority, evaluated in the same cycle:
  1. All data bits = 0, parity bit = 0 (if present) and any stop bit = 0: break_det pulse -> BREAK_WAIT. Nothing is pushed, and no frame_err or parity_err pulse is raised.
  2. Any stop bit = 0: frame_err pulse, no push -> IDLE.
  3. Parity mismatch: parity_err pulse, no push -> IDLE.
  4. Otherwise push the character; if the FIFO is full and not popping this cycle, pulse overrun and drop the new character (FIFO contents unchanged). -> IDLE.
- BREAK_WAIT -> IDLE once the synchronised line has been 1 for one full clk. No start detection occurs while in BREAK_WAIT.
- FIFO:
  - Show-ahead: rd_data = head entry whenever rd_valid = 1. rd_data holds its last value when empty.
  - Pop on rd_valid & rd_ready. rd_ready while empty is ignored.
  - Push on a good frame, registered. rd_valid rises the clk after the decision cycle, so latency from the last-stop-bit count-9 tick is 1 clk.
  - Simultaneous push and pop: when full, the push is accepted and no overrun occurs. When empty, the pushed data is not visible until the next cycle, and the pop is ignored.
  - fifo_count is updated with the same register timing as rd_valid. Pointers wrap modulo FIFO_DEPTH.
- Width rules: the shift register is DATA_BITS wide. Parity is the XOR over DATA_BITS bits only.

Test Plan:
All scenarios use SYSCLK_FREQ = 1600000, BAUD_RATE = 100000 (tick every clk, 16 clk/bit), DATA_BITS = 8, PARITY = 0, STOP_BITS = 1 unless noted.
- 8N1 0xA5, rd_ready = 0: rd_valid = 1, rd_data = 0xA5 and fifo_count = 1 exactly 1 clk after the stop-bit count-9 tick; no error pulses.
- PARITY = 2, STOP_BITS = 2: send 0x3C with parity 0 -> accepted. Send 0x3D with parity 0 -> parity_err pulse, fifo_count unchanged. Send 0x3C with the 2nd stop bit low -> frame_err pulse, no push.
- 3-clk low glitch on an idle line -> state returns to IDLE, no pulses, no push. Then a valid 0x55 frame is received correctly.
- Line held low for 20 bit times -> single break_det pulse, no frame_err, no push. No new start is detected until the line returns high. Then 0x12 is received correctly.
- FIFO_DEPTH = 4, rd_ready = 0, send 0x01..0x05 back-to-back -> overrun pulse on the 5th frame; FIFO pops 0x01..0x04 in order. Repeat with rd_ready = 1 asserted during the 5th frame decision -> no overrun, 0x05 retained.
- Assert rst mid-DATA of frame 0x77 -> all outputs 0 immediately. Release rst, send 0x88 -> only 0x88 is received.

Source files
------------

// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param : 16x-oversampled UART receiver, configurable frame format,
//                 error/break detection and a show-ahead receive FIFO.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_param #(
    parameter int SYSCLK_FREQ = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          c_aw    = $clog2(FIFO_DEPTH);
    localparam int          c_cw    = c_aw + 1;
    localparam logic [31:0] c_inc   = 32'(16 * BAUD_RATE);
    localparam logic [31:0] c_clk   = 32'(SYSCLK_FREQ);
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, hist_q;
    logic [31:0]            acc_q, acc_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   s7_q, s7_d, s8_q, s8_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_bad_q, par_bad_d;
    logic                   stop_low_q, stop_low_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   break_q, break_d;
    logic                   overrun_q, overrun_d;
    logic [c_aw-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   w_fall, w_run, w_tick, w_maj, w_stop_low, w_xor;
    logic [32:0]            w_sum;
    logic [31:0]            w_sub;
    logic                   w_push, w_pop, w_full, w_push_ok;
    logic [c_aw-1:0]        w_rd_nx;

    assign w_fall     = hist_q & ~sync2_q;
    assign w_run      = (state_q != S_IDLE) && (state_q != S_BREAK_WAIT);
    assign w_sum      = {1'b0, acc_q} + {1'b0, c_inc};
    assign w_sub      = w_sum[31:0] - c_clk;
    assign w_tick     = w_run && (w_sum >= {1'b0, c_clk});
    assign w_maj      = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
    assign w_stop_low = stop_low_q | ~w_maj;
    assign w_xor      = (^shift_q) ^ w_maj;
    assign w_pop      = rd_valid & rd_ready;
    assign w_full     = (count_q == c_depth);
    assign w_rd_nx    = rd_ptr_q + c_aw'(1);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        par_bad_d    = par_bad_q;
        stop_low_d   = stop_low_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        break_d      = 1'b0;
        w_push       = 1'b0;

        if (w_run) begin
            acc_d = w_tick ? w_sub : w_sum[31:0];
        end
        if (w_tick) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) s7_d = sync2_q;
            if (cnt_q == 4'd8) s8_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d    = S_START;
                    acc_d      = '0;
                    cnt_d      = '0;
                    bitcnt_d   = '0;
                    par_bit_d  = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_low_d = 1'b0;
                end
            end
            S_START: begin
                if (w_tick && cnt_q == 4'd9 && w_maj) begin
                    state_d = S_IDLE;
                end else if (w_tick && cnt_q == 4'd15) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                if (w_tick && cnt_q == 4'd9) begin
                    shift_d  = {w_maj, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (w_tick && cnt_q == 4'd15 && bitcnt_q == 4'(DATA_BITS)) begin
                    state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    bitcnt_d = '0;
                end
            end
            S_PARITY: begin
                if (w_tick && cnt_q == 4'd9) begin
                    par_bit_d = w_maj;
                    par_bad_d = (PARITY == 1) ? ~w_xor : w_xor;
                end else if (w_tick && cnt_q == 4'd15) begin
                    state_d  = S_STOP;
                    bitcnt_d = '0;
                end
            end
            S_STOP: begin
                // Decide mid-way through the last stop bit so a following start edge is not missed
                if (w_tick && cnt_q == 4'd9) begin
                    if (bitcnt_q == 4'(STOP_BITS - 1)) begin
                        if (shift_q == '0 && (PARITY == 0 || !par_bit_q) && w_stop_low) begin
                            break_d = 1'b1;
                            state_d = S_BREAK_WAIT;
                        end else begin
                            state_d = S_IDLE;
                            if (w_stop_low)     frame_err_d  = 1'b1;
                            else if (par_bad_q) parity_err_d = 1'b1;
                            else                w_push       = 1'b1;
                        end
                    end else begin
                        stop_low_d = w_stop_low;
                        bitcnt_d   = bitcnt_q + 4'd1;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Receive FIFO; a full FIFO still accepts a push when the head is popped
        w_push_ok = w_push & (~w_full | w_pop);
        overrun_d = w_push & w_full & ~w_pop;
        wr_ptr_d  = wr_ptr_q + c_aw'(w_push_ok);
        rd_ptr_d  = rd_ptr_q + c_aw'(w_pop);
        count_d   = count_q + c_cw'(w_push_ok) - c_cw'(w_pop);
        rd_data_d = rd_data_q;
        if (w_pop) begin
            if (count_q == c_cw'(1)) begin
                if (w_push_ok) rd_data_d = shift_q;
            end else begin
                rd_data_d = mem_q[w_rd_nx];
            end
        end else if (count_q == '0 && w_push_ok) begin
            rd_data_d = shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            hist_q       <= 1'b1;
            acc_q        <= '0;
            cnt_q        <= '0;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            stop_low_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            par_bad_q    <= par_bad_d;
            stop_low_q   <= stop_low_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// tb_uart_rx_param : directed bench for uart_rx_param (8N1 and 8E2 instances)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b;
    logic       fe_a, pe_a, brk_a, ovr_a;
    logic       fe_b, pe_b, brk_b, ovr_b;
    logic [2:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int n_fe_a = 0, n_pe_a = 0, n_brk_a = 0, n_ovr_a = 0;
    int n_fe_b = 0, n_pe_b = 0, n_brk_b = 0, n_ovr_b = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .SYSCLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .uart_rx(rx_a),
        .rd_data(data_a), .rd_valid(val_a), .rd_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .break_det(brk_a),
        .overrun(ovr_a), .fifo_count(cnt_a)
    );

    uart_rx_param #(
        .SYSCLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .uart_rx(rx_b),
        .rd_data(data_b), .rd_valid(val_b), .rd_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .break_det(brk_b),
        .overrun(ovr_b), .fifo_count(cnt_b)
    );

    // Pulse tallies, sampled on the inactive edge
    always @(negedge clk) begin
        if (fe_a)  n_fe_a  <= n_fe_a + 1;
        if (pe_a)  n_pe_a  <= n_pe_a + 1;
        if (brk_a) n_brk_a <= n_brk_a + 1;
        if (ovr_a) n_ovr_a <= n_ovr_a + 1;
        if (fe_b)  n_fe_b  <= n_fe_b + 1;
        if (pe_b)  n_pe_b  <= n_pe_b + 1;
        if (brk_b) n_brk_b <= n_brk_b + 1;
        if (ovr_b) n_ovr_b <= n_ovr_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit which, input logic b, input int n);
        if (which) rx_b = b;
        else       rx_a = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        drive(1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(1'b0, d[i], 16);
        drive(1'b0, 1'b1, 16);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par, input logic stop2);
        drive(1'b1, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(1'b1, d[i], 16);
        drive(1'b1, par, 16);
        drive(1'b1, 1'b1, 16);
        drive(1'b1, stop2, 16);
    endtask

    task automatic pop_a();
        rdy_a = 1'b1;
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
    endtask

    logic [7:0] d5;

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        d5 = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, val_a}, 32'd0);
        chk("reset_count", {29'd0, cnt_a}, 32'd0);
        chk("reset_data",  {24'd0, data_a}, 32'd0);
        chk("reset_pulses", {28'd0, fe_a, pe_a, brk_a, ovr_a}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 10);

        // rd_ready on an empty FIFO is ignored
        rdy_a = 1'b1;
        drive(1'b0, 1'b1, 3);
        rdy_a = 1'b0;
        chk("empty_pop_count", {29'd0, cnt_a}, 32'd0);

        // 0xA5 with exact push latency
        drive(1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(1'b0, (8'hA5 >> i) & 8'h1, 16);
        drive(1'b0, 1'b1, 12);
        chk("a5_valid_pre", {31'd0, val_a}, 32'd0);
        drive(1'b0, 1'b1, 1);
        chk("a5_valid", {31'd0, val_a}, 32'd1);
        chk("a5_data",  {24'd0, data_a}, 32'hA5);
        chk("a5_count", {29'd0, cnt_a}, 32'd1);
        drive(1'b0, 1'b1, 7);
        chk("a5_no_err", 32'(n_fe_a + n_pe_a + n_brk_a + n_ovr_a), 32'd0);
        pop_a();
        chk("a5_pop_count", {29'd0, cnt_a}, 32'd0);

        // Glitch rejection, then 0x55
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 40);
        chk("glitch_count", {29'd0, cnt_a}, 32'd0);
        chk("glitch_no_err", 32'(n_fe_a + n_pe_a + n_brk_a + n_ovr_a), 32'd0);
        send_a(8'h55);
        chk("55_count", {29'd0, cnt_a}, 32'd1);
        chk("55_data",  {24'd0, data_a}, 32'h55);
        pop_a();

        // Break: 20 bit times low
        drive(1'b0, 1'b0, 320);
        drive(1'b0, 1'b1, 32);
        chk("break_pulses", 32'(n_brk_a), 32'd1);
        chk("break_no_fe",  32'(n_fe_a), 32'd0);
        chk("break_count",  {29'd0, cnt_a}, 32'd0);
        send_a(8'h12);
        chk("12_count", {29'd0, cnt_a}, 32'd1);
        chk("12_data",  {24'd0, data_a}, 32'h12);
        pop_a();

        // Overrun on fifth back-to-back frame
        for (int i = 1; i <= 5; i++) send_a(8'(i));
        drive(1'b0, 1'b1, 4);
        chk("ovr_pulse", 32'(n_ovr_a), 32'd1);
        chk("ovr_count", {29'd0, cnt_a}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_drain", {24'd0, data_a}, 32'(i));
            pop_a();
        end
        chk("ovr_empty", {29'd0, cnt_a}, 32'd0);

        // Full FIFO with pop during the decision cycle: push accepted
        for (int i = 1; i <= 4; i++) send_a(8'(i));
        drive(1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(1'b0, d5[i], 16);
        drive(1'b0, 1'b1, 12);
        rdy_a = 1'b1;
        drive(1'b0, 1'b1, 1);
        rdy_a = 1'b0;
        drive(1'b0, 1'b1, 6);
        chk("popfull_no_ovr", 32'(n_ovr_a), 32'd1);
        chk("popfull_count",  {29'd0, cnt_a}, 32'd4);
        for (int i = 2; i <= 4; i++) begin
            chk("popfull_drain", {24'd0, data_a}, 32'(i));
            pop_a();
        end
        chk("popfull_last", {24'd0, data_a}, 32'h05);

        // 8E2 instance: good, parity error, second stop low
        send_b(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8);
        chk("b_3c_count", {29'd0, cnt_b}, 32'd1);
        chk("b_3c_data",  {24'd0, data_b}, 32'h3C);
        chk("b_3c_no_err", 32'(n_fe_b + n_pe_b + n_brk_b + n_ovr_b), 32'd0);
        send_b(8'h3D, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8);
        chk("b_pe_pulse", 32'(n_pe_b), 32'd1);
        chk("b_pe_count", {29'd0, cnt_b}, 32'd1);
        send_b(8'h3C, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32);
        chk("b_fe_pulse", 32'(n_fe_b), 32'd1);
        chk("b_fe_pe",    32'(n_pe_b), 32'd1);
        chk("b_fe_count", {29'd0, cnt_b}, 32'd1);
        chk("b_fe_data",  {24'd0, data_b}, 32'h3C);

        // Reset in the middle of 0x77
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b1, 8);
        rst = 1'b1;
        #1;
        chk("rst_a_valid", {31'd0, val_a}, 32'd0);
        chk("rst_a_data",  {24'd0, data_a}, 32'd0);
        chk("rst_a_count", {29'd0, cnt_a}, 32'd0);
        chk("rst_b_count", {29'd0, cnt_b}, 32'd0);
        chk("rst_b_data",  {24'd0, data_b}, 32'd0);
        rx_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 20);
        send_a(8'h88);
        drive(1'b0, 1'b1, 4);
        chk("88_count", {29'd0, cnt_a}, 32'd1);
        chk("88_data",  {24'd0, data_a}, 32'h88);
        chk("88_no_fe", 32'(n_fe_a + n_pe_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
